// File: rtl/mult_arbiter_if.sv
// Bundle of every handshake and bus signal around mult_arbiter.
// Carries the two requester channels (operand request + product response),
// the start/done link to the shared shift-add multiplier core, and the
// busy / timeout_err status outputs.
//   slave  : view taken by mult_arbiter itself
//   master : view taken by whatever drives the requesters and the core
interface mult_arbiter_if #(
  parameter int W = 4
);

  logic         req0_valid;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_ready;
  logic         rsp0_valid;
  logic [2*W-1:0] rsp0_p;

  logic         req1_valid;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_ready;
  logic         rsp1_valid;
  logic [2*W-1:0] rsp1_p;

  logic         mul_start;
  logic [W-1:0] mul_a;
  logic [W-1:0] mul_b;
  logic         mul_done;
  logic [2*W-1:0] mul_p;

  logic         busy;
  logic         timeout_err;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    output req0_ready, rsp0_valid, rsp0_p,
    input  req1_valid, req1_a, req1_b,
    output req1_ready, rsp1_valid, rsp1_p,
    output mul_start, mul_a, mul_b,
    input  mul_done, mul_p,
    output busy, timeout_err
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    input  req0_ready, rsp0_valid, rsp0_p,
    output req1_valid, req1_a, req1_b,
    input  req1_ready, rsp1_valid, rsp1_p,
    input  mul_start, mul_a, mul_b,
    output mul_done, mul_p,
    input  busy, timeout_err
  );

endinterface

// File: rtl/mult_arbiter.sv
// Round-robin sequencer sharing one shift-add multiplier core between two
// requesters. An operand pair is accepted in IDLE, the core is kicked with a
// one-cycle start in ISSUE, WAIT sits on the core's done under a watchdog,
// and RESP returns the product to the owning requester as a one-cycle pulse.
// Ports:
//   sys_clk  : rising-edge clock for all logic
//   sys_rst  : synchronous active-high reset
//   bus      : mult_arbiter_if.slave (requester channels, core link, status)
// Parameters:
//   W        : operand width, product is 2W
//   TIMEOUT  : WAIT cycles allowed before the watchdog aborts (>= 1)
module mult_arbiter #(
  parameter int W       = 4,
  parameter int TIMEOUT = 31
) (
  input logic           sys_clk,
  input logic           sys_rst,
  mult_arbiter_if.slave bus
);

  localparam int                 TIMER_W   = $clog2(TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_V = TIMER_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       op_a_q, op_a_d;
  logic [W-1:0]       op_b_q, op_b_d;
  logic               owner_q, owner_d;
  logic               last_grant_q, last_grant_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [TIMER_W-1:0] timer_inc;
  logic [2*W-1:0]     rsp0_p_q, rsp0_p_d;
  logic [2*W-1:0]     rsp1_p_q, rsp1_p_d;
  logic               timeout_err_q, timeout_err_d;

  logic               grant;
  logic               accept;

  // Arbitration: a lone valid requester wins outright; on a tie the
  // requester that was not served last wins. With no valid requester the
  // grant value is irrelevant because accept stays low.
  always_comb begin
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_grant_q;
    end else begin
      grant = bus.req1_valid;
    end
    accept = (state_q == IDLE) && (bus.req0_valid || bus.req1_valid);
  end

  // State register plus all datapath registers. Reset puts last_grant at 1
  // so requester 0 wins the first tie.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q       <= IDLE;
      op_a_q        <= '0;
      op_b_q        <= '0;
      owner_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      timer_q       <= '0;
      rsp0_p_q      <= '0;
      rsp1_p_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      owner_q       <= owner_d;
      last_grant_q  <= last_grant_d;
      timer_q       <= timer_d;
      rsp0_p_q      <= rsp0_p_d;
      rsp1_p_q      <= rsp1_p_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state logic. timer_inc is the number of WAIT cycles spent so far
  // including the current one, so the watchdog fires on WAIT cycle TIMEOUT.
  // done is only honoured in WAIT and has priority over the watchdog.
  always_comb begin
    state_d       = state_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    timer_d       = timer_q;
    rsp0_p_d      = rsp0_p_q;
    rsp1_p_d      = rsp1_p_q;
    timeout_err_d = 1'b0;
    timer_inc     = timer_q + TIMER_W'(1);

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_a_d  = grant ? bus.req1_a : bus.req0_a;
          op_b_d  = grant ? bus.req1_b : bus.req0_b;
          owner_d = grant;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_inc;
        if (bus.mul_done) begin
          if (owner_q) begin
            rsp1_p_d = bus.mul_p;
          end else begin
            rsp0_p_d = bus.mul_p;
          end
          state_d = RESP;
        end else if (timer_inc == TIMEOUT_V) begin
          if (owner_q) begin
            rsp1_p_d = '0;
          end else begin
            rsp0_p_d = '0;
          end
          timeout_err_d = 1'b1;
          state_d       = RESP;
        end
      end
      RESP: begin
        last_grant_d = owner_q;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from the current state and registers. Ready is offered
  // only in IDLE and only to the granted requester.
  always_comb begin
    bus.req0_ready  = accept && !grant;
    bus.req1_ready  = accept && grant;
    bus.mul_start   = (state_q == ISSUE);
    bus.mul_a       = op_a_q;
    bus.mul_b       = op_b_q;
    bus.rsp0_valid  = (state_q == RESP) && !owner_q;
    bus.rsp1_valid  = (state_q == RESP) && owner_q;
    bus.rsp0_p      = rsp0_p_q;
    bus.rsp1_p      = rsp1_p_q;
    bus.busy        = (state_q != IDLE);
    bus.timeout_err = timeout_err_q;
  end

endmodule
